// File: rtl/cbus_arbiter_pkg.sv
// Cache-bus types shared by the L1 caches, the arbiter and the memory side.
// Provides the request/response payloads (cbus_req_t, cbus_resp_t), the
// MSIZE*/MLEN*/AXI_BURST_* encodings and the arbiter state type used by
// visibility tooling. No ports.
package cbus_arbiter_pkg;

    localparam int unsigned CBUS_ADDR_W = 32;
    localparam int unsigned CBUS_DATA_W = 64;
    localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

    // Bytes per beat
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Burst length encoded as beats-1
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        msize_t                 size;
        mlen_t                  len;
        axi_burst_type_t        burst;
        logic [CBUS_DATA_W-1:0] data;
        logic [CBUS_STRB_W-1:0] strobe;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } cbus_arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Round-robin winner selection: returns the first set request bit found by
// scanning upward from `start`, wrapping past the top port back to 0.
// Only built when CBUS_ARB_ROUND_ROBIN_EN is defined.
// Ports:
//   reqs   in  NUM_PORTS  request bits, one per port
//   start  in  SEL_BITS   index to begin scanning from
//   idx    out SEL_BITS   winning index (0 when nothing requests)
//   found  out 1          any request bit set
`ifdef CBUS_ARB_ROUND_ROBIN_EN
module cbus_arbiter_rr_picker #(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned SEL_BITS  = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] reqs,
    input  logic [SEL_BITS-1:0]  start,
    output logic [SEL_BITS-1:0]  idx,
    output logic                 found
);

    logic [SEL_BITS-1:0] cand;

    // Scan from the far end back toward start so the closest candidate wins.
    always_comb begin
        idx   = '0;
        cand  = '0;
        found = |reqs;
        for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
            cand = SEL_BITS'((int'(start) + k) % int'(NUM_PORTS));
            if (reqs[cand]) begin
                idx = cand;
            end
        end
    end

endmodule
`endif

// File: rtl/cbus_arbiter.sv
// Arbiter between the L1 requesters and the single memory-side cache bus.
// One port is granted at a time and keeps the grant for its whole burst,
// until the response beat carrying `last`. The granted request is forwarded
// unchanged and the response is routed back to that port only.
// Build option: CBUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest valid index wins (fixed priority).
// Ports:
//   clk        in  1          system clock
//   reset      in  1          asynchronous, active-high reset
//   ireqs      in  NUM_PORTS  upstream requests, index 0 highest fixed priority
//   iresps     out NUM_PORTS  upstream responses, only the granted port active
//   oreq       out            request to memory/interconnect
//   oresp      in             response from memory/interconnect
//   busy       out 1          high while a grant is held
//   grant_idx  out SEL_BITS   current or last granted port
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned SEL_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  cbus_req_t           ireqs  [NUM_PORTS],
    output cbus_resp_t          iresps [NUM_PORTS],
    output cbus_req_t           oreq,
    input  cbus_resp_t          oresp,
    output logic                busy,
    output logic [SEL_BITS-1:0] grant_idx
);

    cbus_arb_state_t     state;
    logic [SEL_BITS-1:0] sel;
    logic [SEL_BITS-1:0] win;
    logic                any_valid;
    logic [3:0]          beats;
    logic [NUM_PORTS-1:0] valids;

    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            valids[i] = ireqs[i].valid;
        end
    end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [SEL_BITS-1:0] rr;

    cbus_arbiter_rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_picker (
        .reqs  (valids),
        .start (rr),
        .idx   (win),
        .found (any_valid)
    );
`else
    // Fixed priority: lowest valid index wins.
    always_comb begin
        win       = '0;
        any_valid = |valids;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (valids[i]) begin
                win = SEL_BITS'(i);
            end
        end
    end
`endif

    // Grant state; only the winner index is captured, request fields are not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            beats <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            rr    <= '0;
`endif
        end else if (state == IDLE) begin
            if (any_valid) begin
                state <= BUSY;
                sel   <= win;
                beats <= '0;
            end
        end else begin
            if (oresp.ready) begin
                beats <= beats + 4'd1;
            end
            // Only `last` ends the burst, even if the requester dropped valid.
            if (oresp.ready && oresp.last) begin
                state <= IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                rr    <= SEL_BITS'((32'(sel) + 32'd1) % NUM_PORTS);
`endif
            end
        end
    end

    // Forward path and response routing; everything quiet while IDLE.
    always_comb begin
        oreq = '0;
        busy = (state == BUSY);
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            iresps[i] = '0;
            if (busy && (SEL_BITS'(i) == sel)) begin
                iresps[i] = oresp;
            end
        end
        if (busy) begin
            oreq = ireqs[sel];
        end
    end

    assign grant_idx = sel;

    // Burst length sanity: the last beat must land on the requested length.
    always_ff @(posedge clk) begin
        if (state == BUSY && oresp.ready && oresp.last &&
            (5'(beats) + 5'd1 != 5'(oreq.len) + 5'd1)) begin
            $error("cbus_arbiter: last after %0d beats, len field expects %0d",
                   5'(beats) + 5'd1, 5'(oreq.len) + 5'd1);
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter with two ports. Stimulus pushes expected
// grants and response beats into queues; a negedge monitor pops and compares
// whenever the arbiter presents a new grant or a routed response beat.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned NP = 2;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [NP];
    cbus_resp_t iresps [NP];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       busy;
    logic [0:0] grant_idx;

    cbus_arbiter #(
        .NUM_PORTS (NP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        port;
        cbus_req_t req;
    } grant_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        last;
    } beat_t;

    grant_t gq[$];
    beat_t  bq[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                         input msize_t sz, input mlen_t ln,
                                         input logic [63:0] d, input logic [7:0] strb);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.size     = sz;
        r.len      = ln;
        r.burst    = AXI_BURST_INCR;
        r.data     = d;
        r.strobe   = strb;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int port, input cbus_req_t r);
        grant_t g;
        g.port = port;
        g.req  = r;
        gq.push_back(g);
    endtask

    task automatic expect_beat(input int port, input logic [63:0] d, input logic last);
        beat_t b;
        b.port = port;
        b.data = d;
        b.last = last;
        bq.push_back(b);
    endtask

    task automatic wait_grant();
        for (int c = 0; c < 20 && !busy; c++) begin
            tick();
        end
        check("grant_timeout", 128'(busy), 128'(1));
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic last);
        oresp.ready = 1'b1;
        oresp.last  = last;
        oresp.data  = d;
    endtask

    // Memory-side model: wait for the grant, then return nbeats back-to-back.
    task automatic serve(input int port, input int nbeats, input logic [63:0] base);
        wait_grant();
        for (int b = 0; b < nbeats; b++) begin
            expect_beat(port, base + 64'(b), b == nbeats - 1);
            drive_beat(base + 64'(b), b == nbeats - 1);
            tick();
        end
        oresp = '0;
    endtask

    // Monitor
    grant_t     m_g;
    beat_t      m_b;
    int         m_cnt;
    int         m_idx;
    cbus_resp_t m_resp;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy) begin
                for (int i = 0; i < int'(NP); i++) begin
                    check($sformatf("idle_iresps%0d", i), 128'(iresps[i]), 128'(0));
                end
            end else begin
                if (!prev_busy) begin
                    if (gq.size() == 0) begin
                        check("unexpected_grant", 128'(1), 128'(0));
                    end else begin
                        m_g = gq.pop_front();
                        check("grant_idx", 128'(grant_idx), 128'(m_g.port));
                        check("oreq_fields", 128'(oreq), 128'(m_g.req));
                    end
                end
                m_cnt  = 0;
                m_idx  = -1;
                m_resp = '0;
                for (int i = 0; i < int'(NP); i++) begin
                    if (iresps[i].ready) begin
                        m_cnt++;
                        m_idx  = i;
                        m_resp = iresps[i];
                    end
                    if (i != int'(grant_idx)) begin
                        check($sformatf("unsel_iresps%0d", i), 128'(iresps[i]), 128'(0));
                    end
                end
                if (m_cnt > 0) begin
                    if (bq.size() == 0) begin
                        check("unexpected_beat", 128'(1), 128'(0));
                    end else begin
                        m_b = bq.pop_front();
                        check("beat_port_count", 128'(m_cnt), 128'(1));
                        check("beat_port", 128'(m_idx), 128'(m_b.port));
                        check("beat_data", 128'(m_resp.data), 128'(m_b.data));
                        check("beat_last", 128'(m_resp.last), 128'(m_b.last));
                    end
                end
            end
            prev_busy <= busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cbus_req_t r, r0, r1, ra, rb;
        int        port;

        reset = 1'b0;
        oresp = '0;
        for (int i = 0; i < int'(NP); i++) begin
            ireqs[i] = '0;
        end
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_grant_idx", 128'(grant_idx), 128'(0));
        check("rst_oreq", 128'(oreq), 128'(0));
        check("rst_iresps0", 128'(iresps[0]), 128'(0));
        check("rst_iresps1", 128'(iresps[1]), 128'(0));
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single requester, 16-beat read on port 1
        r = mk_req(1'b0, 32'h8000_0080, MSIZE8, MLEN16, 64'h0, 8'h00);
        expect_grant(1, r);
        ireqs[1] = r;
        tick();
        check("t1_addr", 128'(oreq.addr), 128'(32'h8000_0080));
        check("t1_busy_rise", 128'(busy), 128'(1));
        serve(1, 16, 64'h1000);
        ireqs[1] = '0;
        check("t1_busy_fall", 128'(busy), 128'(0));

        // Simultaneous requests: port 0 first, one idle cycle, then port 1
        r0 = mk_req(1'b0, 32'h1000_0000, MSIZE8, MLEN4, 64'h0, 8'h00);
        r1 = mk_req(1'b0, 32'h2000_0040, MSIZE8, MLEN4, 64'h0, 8'h00);
        expect_grant(0, r0);
        expect_grant(1, r1);
        ireqs[0] = r0;
        ireqs[1] = r1;
        serve(0, 4, 64'h2000);
        ireqs[0] = '0;
        check("t2_idle_gap", 128'(busy), 128'(0));
        tick();
        check("t2_second_grant", 128'(grant_idx), 128'(1));
        serve(1, 4, 64'h3000);
        ireqs[1] = '0;
        check("t2_release", 128'(busy), 128'(0));

        // Both ports continuously valid for four single-beat bursts
        ra = mk_req(1'b0, 32'h3000_0000, MSIZE8, MLEN1, 64'h0, 8'h00);
        rb = mk_req(1'b0, 32'h4000_0000, MSIZE8, MLEN1, 64'h0, 8'h00);
        ireqs[0] = ra;
        ireqs[1] = rb;
        for (int k = 0; k < 4; k++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            port = k % 2;
`else
            port = 0;
`endif
            expect_grant(port, (port == 0) ? ra : rb);
            serve(port, 1, 64'h4000 + 64'(k));
        end
        ireqs[0] = '0;
        ireqs[1] = '0;
        tick();

        // Isolation: ready pulses while idle are ignored
        drive_beat(64'hAAAA, 1'b0);
        tick();
        drive_beat(64'hBBBB, 1'b1);
        tick();
        oresp = '0;
        check("t4_idle_ready_ignored", 128'(busy), 128'(0));

        // Isolation: gapped beats to port 0, port 1 must stay silent
        r = mk_req(1'b0, 32'h5000_0000, MSIZE8, MLEN4, 64'h0, 8'h00);
        expect_grant(0, r);
        ireqs[0] = r;
        wait_grant();
        for (int b = 0; b < 4; b++) begin
            expect_beat(0, 64'h5000 + 64'(b), b == 3);
            drive_beat(64'h5000 + 64'(b), b == 3);
            tick();
            if (b < 3) begin
                oresp.ready = 1'b0;
                oresp.last  = 1'b0;
                oresp.data  = 64'hFFFF;
                tick();
            end
        end
        oresp    = '0;
        ireqs[0] = '0;
        check("t4_release", 128'(busy), 128'(0));

        // Uncached single-beat write on port 1
        r = mk_req(1'b1, 32'h1000_0004, MSIZE4, MLEN1, 64'hDEAD_BEEF, 8'h0F);
        expect_grant(1, r);
        ireqs[1] = r;
        tick();
        check("t5_data", 128'(oreq.data), 128'(64'hDEAD_BEEF));
        check("t5_strobe", 128'(oreq.strobe), 128'(8'h0F));
        check("t5_size", 128'(oreq.size), 128'(MSIZE4));
        serve(1, 1, 64'h0);
        ireqs[1] = '0;
        check("t5_release", 128'(busy), 128'(0));

        // Port 0 burst so that a round-robin pointer would now favour port 1
        r = mk_req(1'b0, 32'h6000_0000, MSIZE8, MLEN1, 64'h0, 8'h00);
        expect_grant(0, r);
        ireqs[0] = r;
        serve(0, 1, 64'h6000);
        ireqs[0] = '0;

        // Reset at beat 5 of a 16-beat fill
        r = mk_req(1'b0, 32'h7000_0000, MSIZE8, MLEN16, 64'h0, 8'h00);
        expect_grant(0, r);
        ireqs[0] = r;
        wait_grant();
        for (int b = 0; b < 5; b++) begin
            expect_beat(0, 64'h7000 + 64'(b), 1'b0);
            drive_beat(64'h7000 + 64'(b), 1'b0);
            tick();
        end
        drive_beat(64'h7005, 1'b0);
        reset = 1'b1;
        #2;
        check("t6_oreq_valid_async", 128'(oreq.valid), 128'(0));
        check("t6_busy_async", 128'(busy), 128'(0));
        check("t6_iresps_async", 128'(iresps[0].ready), 128'(0));
        @(posedge clk);
        #1;
        oresp = '0;
        check("t6_grant_idx_reset", 128'(grant_idx), 128'(0));
        ra = mk_req(1'b0, 32'h8000_0000, MSIZE8, MLEN1, 64'h0, 8'h00);
        rb = mk_req(1'b0, 32'h9000_0000, MSIZE8, MLEN1, 64'h0, 8'h00);
        ireqs[0] = ra;
        ireqs[1] = rb;
        expect_grant(0, ra);
        reset = 1'b0;
        serve(0, 1, 64'h9000);
        ireqs[0] = '0;
        ireqs[1] = '0;
        tick();
        check("t6_release", 128'(busy), 128'(0));

        repeat (3) tick();
        check("grant_queue_empty", 128'(gq.size()), 128'(0));
        check("beat_queue_empty", 128'(bq.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
